// File: rtl/hstm_mc_if.sv
// Handshake/data bundle between requesters and the hstm_mc task engine.
interface hstm_mc_if #(
  parameter int P_NCH        = 4,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CNT_WIDTH  = 8
);
  localparam int GW = (P_NCH > 1) ? $clog2(P_NCH) : 1;

  logic [P_NCH-1:0]              req;
  logic [P_CNT_WIDTH-1:0]        busy_len;
  logic [P_NCH-1:0]              busy;
  logic [GW-1:0]                 gnt_id;
  logic [P_NCH-1:0]              done;
  logic [P_NCH-1:0]              err;
  logic [P_NCH*P_DATA_WIDTH-1:0] hstm_data_in;
  logic [P_NCH*P_DATA_WIDTH-1:0] hstm_data_out;

  modport master (
    output req, busy_len, hstm_data_in,
    input  busy, gnt_id, done, err, hstm_data_out
  );

  modport slave (
    input  req, busy_len, hstm_data_in,
    output busy, gnt_id, done, err, hstm_data_out
  );
endinterface

// File: rtl/hstm_mc.sv
// Multi-channel handshake task manager: round-robin grant, timed busy, latch on req release.
// Optional WAIT timeout with sticky per-channel err when HSTM_MC_TIMEOUT_EN is defined.
module hstm_mc #(
  parameter int P_NCH        = 4,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CNT_WIDTH  = 8,
  parameter int P_TMO_CNT    = 1024
) (
  input  logic      clk,
  input  logic      rst,
  hstm_mc_if.slave  bus
);
  localparam int GW = (P_NCH > 1) ? $clog2(P_NCH) : 1;
  typedef logic [GW-1:0] gid_t;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT, S_LATCH} state_t;

  state_t                                 state_q, state_d;
  gid_t                                   gnt_q, gnt_d;
  gid_t                                   last_q, last_d;
  logic [P_CNT_WIDTH-1:0]                 len_q, len_d;
  logic [P_CNT_WIDTH-1:0]                 cnt_q, cnt_d;
  logic [P_NCH-1:0]                       sync1_q, sync2_q, req_s;
  logic [P_NCH-1:0][P_DATA_WIDTH-1:0]     din, dout_q, dout_d;
  logic                                   lat_en;
  logic                                   any_req;
  gid_t                                   pick, cand;

  assign req_s = sync2_q;
  assign din   = bus.hstm_data_in;

`ifdef HSTM_MC_TIMEOUT_EN
  localparam int TW = $clog2(P_TMO_CNT + 1);
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [P_NCH-1:0] err_q, err_d;
`endif

  // First requesting channel strictly after the last served one, wrapping.
  always_comb begin
    any_req = 1'b0;
    pick    = last_q;
    cand    = '0;
    for (int i = 1; i <= P_NCH; i++) begin
      cand = gid_t'((int'(last_q) + i) % P_NCH);
      if (!any_req && req_s[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lat_en  = 1'b0;
`ifdef HSTM_MC_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          len_d   = (bus.busy_len == '0) ? P_CNT_WIDTH'(1) : bus.busy_len;
          cnt_d   = '0;
          state_d = S_BUSY;
`ifdef HSTM_MC_TIMEOUT_EN
          err_d[pick] = 1'b0;
`endif
        end
      end
      S_BUSY: begin
        if (cnt_q == len_q - 1'b1) begin
          state_d = S_WAIT;
`ifdef HSTM_MC_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!req_s[gnt_q]) begin
          state_d = S_LATCH;
`ifdef HSTM_MC_TIMEOUT_EN
        end else if (tmo_q == TW'(P_TMO_CNT - 1)) begin
          // Abandon the stuck channel but still rotate so others get service.
          err_d[gnt_q] = 1'b1;
          last_d       = gnt_q;
          state_d      = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      S_LATCH: begin
        lat_en  = 1'b1;
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    if (lat_en) dout_d[gnt_q] = din[gnt_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= gid_t'(P_NCH - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sync1_q <= bus.req;
      sync2_q <= sync1_q;
      dout_q  <= dout_d;
    end
  end

`ifdef HSTM_MC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = '0;
`endif

  assign bus.busy          = (state_q == S_BUSY)  ? (P_NCH'(1) << gnt_q) : '0;
  assign bus.done          = (state_q == S_LATCH) ? (P_NCH'(1) << gnt_q) : '0;
  assign bus.gnt_id        = gnt_q;
  assign bus.hstm_data_out = dout_q;
endmodule
